ram_bist_master: RTL and testbench

- Bus initiator for the single-port 32-bit word RAM interface: req/we/be/addr/wdata out, rvalid/rdata in, with a fixed 1-cycle read latency and no grant.
- On start, it writes a deterministic pattern over Depth words, reads them back pipelined, and reports pass/fail, an error count and the first failing address.
- Used for on-board memory self-test after configuration and as a traffic generator for the RAM in FPGA bring-up.

---
 rtl/ram_bist_master.sv | 173 +++++++++++++++++
 tb/tb_ram_bist_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_master.sv
// ram_bist_master: write/read-back self-test initiator for a 1-cycle-latency 32-bit word RAM.
// Define RAM_BIST_INVERT_PASS_EN to add a second pass that writes and checks the inverted pattern.
module ram_bist_master #(
  parameter int unsigned Depth    = 128,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  output logic        req_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  localparam int unsigned     IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWrite    = 3'd1;
  localparam logic [2:0] StRead     = 3'd2;
  localparam logic [2:0] StDrain    = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;
`ifdef RAM_BIST_INVERT_PASS_EN
  localparam logic [2:0] StWriteInv = 3'd5;
  localparam logic [2:0] StReadInv  = 3'd6;
`endif

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     seed_q, seed_d;
  logic            pend_q;
  logic [31:0]     expData_q, expAddr_q;
  logic [15:0]     errCount_q, errCount_d;
  logic [31:0]     firstErr_q, firstErr_d;

  logic        isWrite, isRead, invert;
  logic [31:0] pat, patSel, curAddr;
  logic        rspErr;

  // Write/read phases share one index; the inverted pass only flips the data polarity.
  always_comb begin
    isWrite = (state_q == StWrite);
    isRead  = (state_q == StRead);
    invert  = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
    if (state_q == StWriteInv) begin
      isWrite = 1'b1;
      invert  = 1'b1;
    end
    if (state_q == StReadInv) begin
      isRead = 1'b1;
      invert = 1'b1;
    end
`endif
  end

  assign pat     = seed_q + 32'(idx_q);
  assign patSel  = invert ? ~pat : pat;
  assign curAddr = BaseAddr + (32'(idx_q) << 2);

  assign req_o   = isWrite | isRead;
  assign we_o    = isWrite;
  assign be_o    = req_o ? 4'hF : 4'h0;
  assign addr_o  = req_o ? curAddr : 32'h0;
  assign wdata_o = isWrite ? patSel : 32'h0;

  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign done_o           = (state_q == StDone);
  assign pass_o           = done_o && (errCount_q == 16'h0);
  assign err_count_o      = errCount_q;
  assign first_err_addr_o = firstErr_q;

  // A pending read fails on wrong data or on a missing response.
  assign rspErr = pend_q && (!rvalid_i || (rdata_i != expData_q));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seed_d     = seed_q;
    errCount_d = errCount_q;
    firstErr_d = firstErr_q;

    if (rspErr) begin
      if (errCount_q != 16'hFFFF) errCount_d = errCount_q + 16'd1;
      if (errCount_q == 16'h0)    firstErr_d = expAddr_q;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          seed_d     = seed_i;
          errCount_d = 16'h0;
          firstErr_d = 32'h0;
          idx_d      = '0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StRead;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StRead: begin
        if (idx_q == LastIdx) begin
          idx_d = '0;
`ifdef RAM_BIST_INVERT_PASS_EN
          state_d = StWriteInv;
`else
          state_d = StDrain;
`endif
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
`ifdef RAM_BIST_INVERT_PASS_EN
      StWriteInv: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StReadInv;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StReadInv: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
`endif
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      seed_q     <= 32'h0;
      pend_q     <= 1'b0;
      expData_q  <= 32'h0;
      expAddr_q  <= 32'h0;
      errCount_q <= 16'h0;
      firstErr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seed_q     <= seed_d;
      pend_q     <= isRead;
      expData_q  <= isRead ? patSel : 32'h0;
      expAddr_q  <= isRead ? curAddr : 32'h0;
      errCount_q <= errCount_d;
      firstErr_q <= firstErr_d;
    end
  end

endmodule

// File: tb/tb_ram_bist_master.sv
// tb_ram_bist_master: directed bench for ram_bist_master (Depth=8, BaseAddr=0x100) with a fault-injecting RAM model.
// Expectations follow RAM_BIST_INVERT_PASS_EN when it is defined for the build.
module tb_ram_bist_master;

`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int Passes = 2;
`else
  localparam int Passes = 1;
`endif
  localparam int DoneCycle = 2 * Passes * 8 + 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] seed_i;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;
  logic        req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_bist_master #(.Depth(8), .BaseAddr(32'h0000_0100)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  // RAM model: 1-cycle read latency, acks writes too, optional bit-flip, drop and zero faults.
  logic [31:0] mem [8];
  logic [31:0] rd;
  logic [31:0] wrData [$];
  logic [31:0] wrAddr [$];
  int          flipWord = -1;
  int          dropWord = -1;
  bit          zeroRead = 1'b0;
  int          busBad   = 0;

  always @(posedge clk) begin
    if (req_o === 1'b1) begin
      if (be_o !== 4'hF || addr_o[31:5] !== 27'h8 || addr_o[1:0] !== 2'b00) busBad++;
      if (we_o) begin
        mem[addr_o[4:2]] <= wdata_o;
        wrData.push_back(wdata_o);
        wrAddr.push_back(addr_o);
        rvalid_i <= 1'b1;
        rdata_i  <= 32'h0;
      end else begin
        rd = mem[addr_o[4:2]];
        if (zeroRead) rd = 32'h0;
        if (int'(addr_o[4:2]) == flipWord) rd[0] = ~rd[0];
        rdata_i  <= rd;
        rvalid_i <= (int'(addr_o[4:2]) != dropWord);
      end
    end else begin
      rvalid_i <= 1'b0;
      rdata_i  <= 32'h0;
      if (be_o !== 4'h0) busBad++;
    end
  end

  function automatic logic [31:0] memFinal(input logic [31:0] s, input int i);
    return (Passes == 2) ? ~(s + 32'(i)) : (s + 32'(i));
  endfunction

  task automatic runTest(input logic [31:0] seed, output int doneCyc);
    wrData.delete();
    wrAddr.delete();
    @(negedge clk);
    seed_i  = seed;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    doneCyc = -1;
    for (int n = 0; n < 200; n++) begin
      if (done_o === 1'b1) begin
        doneCyc = n + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    seed_i  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_o, we_o, be_o, addr_o, wdata_o} !== 70'h0) begin
      errors++;
      $display("[TB] FAIL reset_ram_outputs: got req=%b we=%b be=%h addr=%h wdata=%h required all 0", req_o, we_o, be_o, addr_o, wdata_o);
    end
    checks++;
    if ({busy_o, done_o, pass_o, err_count_o, first_err_addr_o} !== 51'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got busy=%b done=%b pass=%b err=%h first=%h required all 0", busy_o, done_o, pass_o, err_count_o, first_err_addr_o);
    end
    rst_ni = 1'b1;
    busBad = 0;
  endtask

  task automatic test_ideal;
    int dc;
    logic [31:0] exp;
    runTest(32'h1000_0000, dc);
    checks++;
    if (dc != DoneCycle) begin errors++; $display("[TB] FAIL ideal_done_cycle: got %0d required %0d", dc, DoneCycle); end
    checks++;
    if (pass_o !== 1'b1 || err_count_o !== 16'h0 || first_err_addr_o !== 32'h0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ideal_status: got pass=%b err=%0d first=%h busy=%b required 1 0 0 0", pass_o, err_count_o, first_err_addr_o, busy_o);
    end
    checks++;
    if (wrData.size() != 8 * Passes) begin errors++; $display("[TB] FAIL ideal_write_count: got %0d required %0d", wrData.size(), 8 * Passes); end
    for (int i = 0; i < wrData.size() && i < 16; i++) begin
      exp = (i < 8) ? (32'h1000_0000 + 32'(i)) : ~(32'h1000_0000 + 32'(i - 8));
      checks++;
      if (wrData[i] !== exp) begin errors++; $display("[TB] FAIL ideal_wdata[%0d]: got %h required %h", i, wrData[i], exp); end
    end
    checks++;
    if (wrAddr.size() < 8 || wrAddr[0] !== 32'h100 || wrAddr[7] !== 32'h11C) begin
      errors++;
      $display("[TB] FAIL ideal_write_addrs: first/last write address wrong, entries=%0d required 0x100..0x11C", wrAddr.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== memFinal(32'h1000_0000, i)) begin errors++; $display("[TB] FAIL ideal_mem[%0d]: got %h required %h", i, mem[i], memFinal(32'h1000_0000, i)); end
    end
    checks++;
    if (busBad != 0) begin errors++; $display("[TB] FAIL ideal_bus_protocol: got %0d bad cycles required 0", busBad); end
  endtask

  task automatic test_bit_flip;
    int dc;
    flipWord = 3;
    runTest(32'h1000_0000, dc);
    flipWord = -1;
    checks++;
    if (dc != DoneCycle) begin errors++; $display("[TB] FAIL flip_done_cycle: got %0d required %0d", dc, DoneCycle); end
    checks++;
    if (err_count_o !== 16'(Passes)) begin errors++; $display("[TB] FAIL flip_err_count: got %0d required %0d", err_count_o, Passes); end
    checks++;
    if (first_err_addr_o !== 32'h10C) begin errors++; $display("[TB] FAIL flip_first_addr: got %h required 0000010c", first_err_addr_o); end
    checks++;
    if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL flip_pass: got %b required 0", pass_o); end
  endtask

  task automatic test_back_to_back;
    int dc;
    @(negedge clk);
    seed_i  = 32'h0000_5000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b1 || err_count_o !== 16'h0 || first_err_addr_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL restart_clear: got done=%b busy=%b err=%0d first=%h required 0 1 0 0", done_o, busy_o, err_count_o, first_err_addr_o);
    end
    dc = -1;
    for (int n = 0; n < 200; n++) begin
      if (n == 3) begin start_i = 1'b1; seed_i = 32'hDEAD_BEEF; end
      if (n == 4) start_i = 1'b0;
      if (done_o === 1'b1) begin dc = n + 1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (dc != DoneCycle) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d required %0d", dc, DoneCycle); end
    checks++;
    if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_pass: got %b required 1", pass_o); end
    for (int i = 0; i < 8; i += 3) begin
      checks++;
      if (mem[i] !== memFinal(32'h0000_5000, i)) begin errors++; $display("[TB] FAIL busy_start_mem[%0d]: got %h required %h", i, mem[i], memFinal(32'h0000_5000, i)); end
    end
  endtask

  task automatic test_wrap;
    int dc;
    logic [31:0] expSeq [4];
    expSeq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    runTest(32'hFFFF_FFFE, dc);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wrData.size() || wrData[i] !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL wrap_wdata[%0d]: got %h required %h", i, (i < wrData.size()) ? wrData[i] : 32'hX, expSeq[i]);
      end
    end
    checks++;
    if (pass_o !== 1'b1 || dc != DoneCycle) begin errors++; $display("[TB] FAIL wrap_pass: got pass=%b cycle=%0d required 1 %0d", pass_o, dc, DoneCycle); end
  endtask

  task automatic test_missing_response;
    int dc;
    dropWord = 7;
    runTest(32'h1000_0000, dc);
    dropWord = -1;
    checks++;
    if (dc != DoneCycle) begin errors++; $display("[TB] FAIL missing_done_cycle: got %0d required %0d", dc, DoneCycle); end
    checks++;
    if (err_count_o !== 16'(Passes)) begin errors++; $display("[TB] FAIL missing_err_count: got %0d required %0d", err_count_o, Passes); end
    checks++;
    if (first_err_addr_o !== 32'h11C || pass_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL missing_first_addr: got addr=%h pass=%b required 0000011c 0", first_err_addr_o, pass_o);
    end
  endtask

  task automatic test_reset_mid;
    int  dc;
    bit  found;
    bit  reqSeen;
    wrData.delete();
    wrAddr.delete();
    @(negedge clk);
    seed_i  = 32'h1000_0000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (req_o === 1'b1 && we_o === 1'b0 && addr_o === 32'h108) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL midreset_find_read2: got no read of 0x108 required one within 40 cycles"); end
    rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    checks++;
    if ({req_o, we_o, be_o, addr_o, wdata_o, busy_o, done_o, pass_o, err_count_o, first_err_addr_o} !== 121'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got req=%b busy=%b addr=%h err=%0d required all 0", req_o, busy_o, addr_o, err_count_o);
    end
    reqSeen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (req_o !== 1'b0) reqSeen = 1'b1;
    end
    checks++;
    if (reqSeen || err_count_o !== 16'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_idle: got reqSeen=%b err=%0d busy=%b done=%b required 0 0 0 0", reqSeen, err_count_o, busy_o, done_o);
    end
    runTest(32'h2000_0000, dc);
    checks++;
    if (dc != DoneCycle || pass_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset_rerun: got cycle=%0d pass=%b required %0d 1", dc, pass_o, DoneCycle); end
  endtask

  task automatic test_zero_read;
    int dc;
    zeroRead = 1'b1;
    runTest(32'h1000_0000, dc);
    checks++;
    if (err_count_o !== 16'(8 * Passes) || first_err_addr_o !== 32'h100 || pass_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_seed1: got err=%0d first=%h pass=%b required %0d 00000100 0", err_count_o, first_err_addr_o, pass_o, 8 * Passes);
    end
    runTest(32'h0, dc);
    zeroRead = 1'b0;
    checks++;
    if (err_count_o !== 16'(8 * Passes - 1) || first_err_addr_o !== 32'h104 || pass_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_seed0: got err=%0d first=%h pass=%b required %0d 00000104 0", err_count_o, first_err_addr_o, pass_o, 8 * Passes - 1);
    end
    checks++;
    if (dc != DoneCycle) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d required %0d", dc, DoneCycle); end
  endtask

  initial begin
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    test_reset();
    test_ideal();
    test_bit_flip();
    test_back_to_back();
    test_wrap();
    test_missing_response();
    test_reset_mid();
    test_zero_read();
    checks++;
    if (busBad != 0) begin errors++; $display("[TB] FAIL bus_protocol_total: got %0d bad cycles required 0", busBad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
